// File: rtl/i2c_rx_pkg.sv
// Shared types and constants for the I2C slave receive controller.
package i2c_rx_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddrRx,
    StAddrSettle,
    StAddrChk,
    StAckWait,
    StAckDrive,
    StDataRx,
    StDataSettle,
    StDataChk,
    StHold
  } state_e;

  localparam logic [1:0] SDA_RELEASE  = 2'b00;
  localparam logic [1:0] SDA_ACK      = 2'b01;
  localparam logic [6:0] GENCALL_ADDR = 7'h00;

endpackage

// File: rtl/i2c_bit_counter.sv
// Per-byte SCL bit counter; cnt_eq8 flags the cycle in which the count becomes 8.
module i2c_bit_counter (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic cnt_eq8
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 4'd0;
    end else if (inc) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Looking at the next value lets the FSM leave the RX state on the 8th edge itself.
  assign cnt_eq8 = (count_d == 4'd8);

endmodule

// File: rtl/i2c_rx_ctrl.sv
// I2C slave receive sequencer: address check, ACK/NACK drive, one-entry data buffer.
// Define I2C_RX_GENCALL_EN to also answer the general-call address 7'h00.
module i2c_rx_ctrl
  import i2c_rx_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       rising_edge_found,
  input  logic       falling_edge_found,
  input  logic [7:0] rx_data,
  output logic       rx_enable,
  output logic [1:0] sda_mode,
  output logic       rw_bit,
  output logic       addr_match,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  input  logic       byte_ready,
  output logic       overrun
);

`ifdef I2C_RX_GENCALL_EN
  localparam bit GencallEn = 1'b1;
`else
  localparam bit GencallEn = 1'b0;
`endif

  state_e     state_q, state_d;
  logic       settle_q, settle_d;
  logic       ack_q, ack_d;
  logic       rx_enable_d, rw_bit_d, addr_match_d, byte_valid_d, overrun_d;
  logic [1:0] sda_mode_d;
  logic [7:0] byte_data_d;
  logic       cnt_eq8, cnt_inc, cnt_clear;
  logic       addr_own, addr_gc, addr_hit;

  assign addr_own = (rx_data[7:1] == SLAVE_ADDR);
  assign addr_gc  = GencallEn && (rx_data[7:1] == GENCALL_ADDR);
  assign addr_hit = addr_own || addr_gc;

  assign cnt_inc   = rising_edge_found && (state_q == StAddrRx || state_q == StDataRx);
  assign cnt_clear = start_found || (state_q == StAckDrive && falling_edge_found);

  i2c_bit_counter u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .cnt_eq8 (cnt_eq8)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      settle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Settle phase lasts two cycles: settle_q marks the second one.
  assign settle_d = (state_q == StAddrSettle || state_q == StDataSettle) && !settle_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:       state_d = StIdle;
      StAddrRx:     if (cnt_eq8) state_d = StAddrSettle;
      StAddrSettle: if (settle_q) state_d = StAddrChk;
      StAddrChk:    state_d = addr_hit ? StAckWait : StHold;
      StAckWait:    if (falling_edge_found) state_d = StAckDrive;
      StAckDrive: begin
        if (falling_edge_found) state_d = (!rw_bit && ack_q) ? StDataRx : StHold;
      end
      StDataRx:     if (cnt_eq8) state_d = StDataSettle;
      StDataSettle: if (settle_q) state_d = StDataChk;
      StDataChk:    state_d = StAckWait;
      StHold:       state_d = StHold;
      default:      state_d = StIdle;
    endcase
    if (stop_found)  state_d = StIdle;
    if (start_found) state_d = StAddrRx;
  end

  always_comb begin
    rx_enable_d  = (state_d == StAddrRx) || (state_d == StDataRx);
    sda_mode_d   = (state_d == StAckDrive && ack_q) ? SDA_ACK : SDA_RELEASE;
    rw_bit_d     = rw_bit;
    addr_match_d = addr_match;
    byte_valid_d = byte_valid;
    byte_data_d  = byte_data;
    overrun_d    = 1'b0;
    ack_d        = ack_q;
    if (byte_valid && byte_ready) byte_valid_d = 1'b0;
    if (start_found || stop_found) begin
      addr_match_d = 1'b0;
    end else begin
      case (state_q)
        StAddrChk: begin
          ack_d = addr_hit;
          if (addr_hit) begin
            rw_bit_d     = addr_own ? rx_data[0] : 1'b0;
            addr_match_d = 1'b1;
          end
        end
        StDataChk: begin
          if (byte_valid && !byte_ready) begin
            overrun_d = 1'b1;
            ack_d     = 1'b0;
          end else begin
            byte_data_d  = rx_data;
            byte_valid_d = 1'b1;
            ack_d        = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_enable  <= 1'b0;
      sda_mode   <= SDA_RELEASE;
      rw_bit     <= 1'b0;
      addr_match <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      overrun    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      rx_enable  <= rx_enable_d;
      sda_mode   <= sda_mode_d;
      rw_bit     <= rw_bit_d;
      addr_match <= addr_match_d;
      byte_valid <= byte_valid_d;
      byte_data  <= byte_data_d;
      overrun    <= overrun_d;
      ack_q      <= ack_d;
    end
  end

endmodule

// File: tb/tb_i2c_rx_ctrl.sv
// Directed, table-driven bench for i2c_rx_ctrl (honours I2C_RX_GENCALL_EN when defined).
module tb_i2c_rx_ctrl;

`ifdef I2C_RX_GENCALL_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start_found, stop_found, rising_edge_found, falling_edge_found;
  logic [7:0] rx_data;
  logic       rx_enable;
  logic [1:0] sda_mode;
  logic       rw_bit, addr_match, byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready, overrun;

  int n_checks = 0;
  int n_errors = 0;
  int ov_cnt = 0;
  logic [7:0] sr = 8'h00;

  i2c_rx_ctrl #(.SLAVE_ADDR(7'h5A)) dut (
    .clk                (clk),
    .rst                (rst),
    .start_found        (start_found),
    .stop_found         (stop_found),
    .rising_edge_found  (rising_edge_found),
    .falling_edge_found (falling_edge_found),
    .rx_data            (rx_data),
    .rx_enable          (rx_enable),
    .sda_mode           (sda_mode),
    .rw_bit             (rw_bit),
    .addr_match         (addr_match),
    .byte_valid         (byte_valid),
    .byte_data          (byte_data),
    .byte_ready         (byte_ready),
    .overrun            (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (overrun) ov_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] addr;
    logic       has_data;
    logic [7:0] data;
    logic       hit;
    logic       rw;
    logic       data_ack;
    logic       valid;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fall();
    falling_edge_found = 1'b1;
    tick();
    falling_edge_found = 1'b0;
  endtask

  task automatic pulse_rise();
    rising_edge_found = 1'b1;
    tick();
    rising_edge_found = 1'b0;
  endtask

  task automatic do_start();
    start_found = 1'b1;
    tick();
    start_found = 1'b0;
  endtask

  task automatic do_stop();
    stop_found = 1'b1;
    tick();
    stop_found = 1'b0;
  endtask

  // Returns right after the cycle that carried the last rising edge.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      pulse_fall();
      tick();
      sr = {sr[6:0], b[7-i]};
      rx_data = sr;
      pulse_rise();
      if (i != n - 1) tick();
    end
  endtask

  task automatic ack_slot(input string name, input logic exp_ack);
    check({name, " sda before slot"}, 32'(sda_mode), 32'd0);
    pulse_fall();
    check({name, " sda in slot"}, 32'(sda_mode), exp_ack ? 32'd1 : 32'd0);
    tick();
    pulse_rise();
    tick();
    pulse_fall();
    check({name, " sda after slot"}, 32'(sda_mode), 32'd0);
  endtask

  initial begin
    int ov0;
    rst = 1'b1;
    start_found = 1'b0;
    stop_found = 1'b0;
    rising_edge_found = 1'b0;
    falling_edge_found = 1'b0;
    rx_data = 8'h00;
    byte_ready = 1'b1;

    vecs[0] = '{8'hB4, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{8'h42, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'hB5, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 8'h00, GC,   1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'hB4, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset rx_enable", 32'(rx_enable), 32'd0);
    check("reset sda_mode", 32'(sda_mode), 32'd0);
    check("reset rw_bit", 32'(rw_bit), 32'd0);
    check("reset addr_match", 32'(addr_match), 32'd0);
    check("reset byte_valid", 32'(byte_valid), 32'd0);
    check("reset byte_data", 32'(byte_data), 32'h00);
    check("reset overrun", 32'(overrun), 32'd0);

    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      do_start();
      check({nm, " rx_enable after start"}, 32'(rx_enable), 32'd1);
      send_bits(vecs[i].addr, 8);
      tick();
      tick();
      tick();
      check({nm, " addr_match"}, 32'(addr_match), 32'(vecs[i].hit));
      if (vecs[i].hit) check({nm, " rw_bit"}, 32'(rw_bit), 32'(vecs[i].rw));
      ack_slot({nm, " addr"}, vecs[i].hit);
      check({nm, " rx_enable after addr ack"}, 32'(rx_enable),
            32'(vecs[i].hit && !vecs[i].rw));
      if (vecs[i].has_data) begin
        send_bits(vecs[i].data, 8);
        tick();
        tick();
        check({nm, " byte_valid early"}, 32'(byte_valid), 32'd0);
        tick();
        check({nm, " byte_valid"}, 32'(byte_valid), 32'(vecs[i].valid));
        if (vecs[i].valid) check({nm, " byte_data"}, 32'(byte_data), 32'(vecs[i].data));
        ack_slot({nm, " data"}, vecs[i].data_ack);
      end
      do_stop();
      check({nm, " addr_match after stop"}, 32'(addr_match), 32'd0);
      check({nm, " rx_enable after stop"}, 32'(rx_enable), 32'd0);
    end

    // Buffer full: second byte is dropped and NACKed.
    byte_ready = 1'b0;
    do_start();
    send_bits(8'hB4, 8);
    tick(); tick(); tick();
    ack_slot("ovr addr", 1'b1);
    send_bits(8'h11, 8);
    tick(); tick(); tick();
    check("ovr first byte_valid", 32'(byte_valid), 32'd1);
    check("ovr first byte_data", 32'(byte_data), 32'h11);
    ack_slot("ovr first", 1'b1);
    send_bits(8'h22, 8);
    tick(); tick();
    ov0 = ov_cnt;
    tick();
    check("ovr overrun pulse", 32'(overrun), 32'd1);
    check("ovr byte_data kept", 32'(byte_data), 32'h11);
    ack_slot("ovr second", 1'b0);
    check("ovr rx_enable in hold", 32'(rx_enable), 32'd0);
    check("ovr pulse count", 32'(ov_cnt - ov0), 32'd1);
    do_stop();
    check("ovr byte_valid survives stop", 32'(byte_valid), 32'd1);
    byte_ready = 1'b1;
    tick();
    check("ovr byte_valid cleared", 32'(byte_valid), 32'd0);

    // Repeated START in the middle of a data byte.
    do_start();
    send_bits(8'hB4, 8);
    tick(); tick(); tick();
    ack_slot("rs addr", 1'b1);
    send_bits(8'hF0, 4);
    tick();
    do_start();
    check("rs rx_enable", 32'(rx_enable), 32'd1);
    check("rs addr_match cleared", 32'(addr_match), 32'd0);
    send_bits(8'hB4, 8);
    tick(); tick(); tick();
    check("rs addr_match", 32'(addr_match), 32'd1);
    ack_slot("rs readdr", 1'b1);
    check("rs no stray byte", 32'(byte_valid), 32'd0);
    do_stop();

    // START and STOP together: START wins.
    start_found = 1'b1;
    stop_found = 1'b1;
    tick();
    start_found = 1'b0;
    stop_found = 1'b0;
    check("start+stop rx_enable", 32'(rx_enable), 32'd1);
    do_stop();
    check("final rx_enable", 32'(rx_enable), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
